// File: rtl/pong_text_buf_if.sv
// Character-write and clear handshake bundle for pong_text_buf.
// The text source drives the master side; the text buffer is the slave.
interface pong_text_buf_if #(
  parameter int COLS = 32,
  parameter int ROWS = 4
) ();
  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          wr_valid;
  logic          wr_ready;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [6:0]    wr_char;
  logic [1:0]    wr_attr;
  logic          clr_req;
  logic          busy;

  modport master (
    output wr_valid, wr_row, wr_col, wr_char, wr_attr, clr_req,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_char, wr_attr, clr_req,
    output wr_ready, busy
  );
endinterface

// File: rtl/pong_text_buf.sv
// Text overlay for the pong display: a ROWS x COLS character buffer rendered
// through an 8x16 glyph ROM into a pixel window, with invert and blink
// attributes and a background clear sweep.

// Glyph ROM: 11-bit address {char, glyph_row}, 8-bit row bitmap, registered
// read. Only the glyphs the overlay uses carry artwork; all others are blank.
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);
  // Row 0 sits in the top byte of each 128-bit glyph.
  localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
  localparam logic [127:0] GLYPH_C = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;

  logic [6:0] idx;
  logic [7:0] rom_d;
  logic [7:0] data_q;

  // Glyph lookup: row r occupies bits [8*(15-r) +: 8].
  always_comb begin
    rom_d = 8'h00;
    idx   = {~addr_i[3:0], 3'b000};
    case (addr_i[10:4])
      7'h41:   rom_d = GLYPH_A[idx +: 8];
      7'h42:   rom_d = GLYPH_B[idx +: 8];
      7'h43:   rom_d = GLYPH_C[idx +: 8];
      default: rom_d = 8'h00;
    endcase
  end

  // One-cycle registered read port.
  always_ff @(posedge clk) begin
    data_q <= rom_d;
  end

  assign data_o = data_q;
endmodule

module pong_text_buf #(
  parameter int COLS         = 32,
  parameter int ROWS         = 4,
  parameter int SCALE        = 1,
  parameter int X0           = 0,
  parameter int Y0           = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [9:0]     x,
  input  logic [9:0]     y,
  pong_text_buf_if.slave bus,
  output logic           text_on,
  output logic [11:0]    text_rgb
);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int WIN_W = (COLS * 8) << SCALE;
  localparam int WIN_H = (ROWS * 16) << SCALE;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          busy_q;
  logic          ready_q;
  logic          init_q;

  logic [31:0]   xs, ys, dx, dy;
  logic          in_win_s0;
  logic [CW-1:0] col_s0;
  logic [RW-1:0] row_s0;
  logic [3:0]    grow_s0;
  logic [2:0]    bit_s0;
  logic [AW-1:0] rd_addr;

  logic [8:0]    mem [DEPTH];
  logic [8:0]    cell_p1;
  logic          win_p1;
  logic [3:0]    grow_p1;
  logic [2:0]    bit_p1;

  logic [7:0]    glyph_p2;
  logic          win_p2;
  logic [2:0]    bit_p2;
  logic [1:0]    attr_p2;
  logic [2:0]    sel_p2;
  logic          text_on_d;
  logic          text_on_q;
  logic [11:0]   text_rgb_q;

  logic          at_origin;
  logic          origin_q;
  logic [7:0]    frame_cnt_q;
  logic          hide_q;

  logic          wr_ready;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [8:0]    mem_wdata;

  // ---- stage 0: window test and cell/glyph coordinates from x,y ----
  // Widened to 32 bits so large windows cannot wrap the comparisons.
  always_comb begin
    xs        = {22'd0, x};
    ys        = {22'd0, y};
    dx        = xs - 32'(X0);
    dy        = ys - 32'(Y0);
    in_win_s0 = (xs >= 32'(X0)) && (xs < 32'(X0 + WIN_W)) &&
                (ys >= 32'(Y0)) && (ys < 32'(Y0 + WIN_H));
    col_s0    = CW'(dx >> (3 + SCALE));
    row_s0    = RW'(dy >> (4 + SCALE));
    grow_s0   = 4'(dy >> SCALE);
    bit_s0    = 3'(dx >> SCALE);
    rd_addr   = AW'((32'(row_s0) << CW) | 32'(col_s0));
  end

  // Write-port arbitration: the clear sweep owns the port while active.
  always_comb begin
    wr_in_range = (32'(bus.wr_row) < 32'(ROWS)) && (32'(bus.wr_col) < 32'(COLS));
    wr_addr     = AW'((32'(bus.wr_row) << CW) | 32'(bus.wr_col));
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q;
    mem_wdata   = 9'h000;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (bus.wr_valid && wr_ready && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = {bus.wr_attr, bus.wr_char};
    end
  end

  // ---- stage 1: character buffer, read-first so a colliding write shows next cycle ----
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    cell_p1 <= mem[rd_addr];
  end

  // ---- stage 2: glyph ROM read addressed by the fetched character ----
  ascii_rom u_rom (
    .clk    (clk),
    .addr_i ({cell_p1[6:0], grow_p1}),
    .data_o (glyph_p2)
  );

  // Bit index 0 is the leftmost pixel, which lives in glyph bit 7.
  assign sel_p2    = ~bit_p2;
  assign text_on_d = win_p2 & (glyph_p2[sel_p2] ^ attr_p2[0]) & ~(attr_p2[1] & hide_q);

  // Side-band pipeline and stage 3 output register, aligned with buffer and ROM reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_p1     <= 1'b0;
      grow_p1    <= 4'd0;
      bit_p1     <= 3'd0;
      win_p2     <= 1'b0;
      bit_p2     <= 3'd0;
      attr_p2    <= 2'd0;
      text_on_q  <= 1'b0;
      text_rgb_q <= 12'h000;
    end else begin
      win_p1     <= in_win_s0;
      grow_p1    <= grow_s0;
      bit_p1     <= bit_s0;
      win_p2     <= win_p1;
      bit_p2     <= bit_p1;
      attr_p2    <= cell_p1[8:7];
      // ---- stage 3: registered pixel output ----
      text_on_q  <= text_on_d;
      text_rgb_q <= text_on_d ? 12'hFFF : 12'h000;
    end
  end

  assign at_origin = (x == 10'd0) && (y == 10'd0);

  // Frame strobe on the first cycle at the origin; counts frames and toggles blink phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      origin_q    <= 1'b0;
      frame_cnt_q <= 8'd0;
      hide_q      <= 1'b0;
    end else begin
      origin_q <= at_origin;
      if (at_origin && !origin_q) begin
        if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= 8'd0;
          hide_q      <= ~hide_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  // Clear controller: an automatic sweep after reset, restartable by clr_req.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.clr_req || init_q) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            init_q     <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (bus.clr_req) begin
            clr_addr_q <= '0;
          end else if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A clear request in the same cycle blocks the write.
  assign wr_ready     = ready_q & ~bus.clr_req;
  assign bus.wr_ready = wr_ready;
  assign bus.busy     = busy_q;
  assign text_on      = text_on_q;
  assign text_rgb     = text_rgb_q;
endmodule

// File: tb/tb_pong_text_buf.sv
// Scoreboard bench for pong_text_buf: pixel stimulus pushes expected output
// computed from a high-level model of the buffer/font/blink rules; a monitor
// pops and compares three cycles later.
module tb_pong_text_buf;
  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int SCALE = 1;
  localparam int X0    = 0;
  localparam int Y0    = 32;
  localparam int BF    = 30;
  localparam int DEPTH = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        text_on;
  logic [11:0] text_rgb;

  pong_text_buf_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  pong_text_buf #(
    .COLS(COLS), .ROWS(ROWS), .SCALE(SCALE), .X0(X0), .Y0(Y0), .BLINK_FRAMES(BF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .x        (x),
    .y        (y),
    .bus      (bus),
    .text_on  (text_on),
    .text_rgb (text_rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  logic [7:0] FA [16] = '{8'h00,8'h00,8'h10,8'h38,8'h6C,8'hC6,8'hC6,8'hFE,
                          8'hC6,8'hC6,8'hC6,8'hC6,8'h00,8'h00,8'h00,8'h00};
  logic [7:0] FB [16] = '{8'h00,8'h00,8'hFC,8'h66,8'h66,8'h66,8'h7C,8'h66,
                          8'h66,8'h66,8'h66,8'hFC,8'h00,8'h00,8'h00,8'h00};
  logic [7:0] FC [16] = '{8'h00,8'h00,8'h3C,8'h66,8'hC2,8'hC0,8'hC0,8'hC0,
                          8'hC0,8'hC2,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00};

  logic [8:0] mbuf [DEPTH];

  typedef struct {
    int   due;
    int   px;
    int   py;
    logic on;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] font(input logic [6:0] ch, input int r);
    case (ch)
      7'h41:   return FA[r];
      7'h42:   return FB[r];
      7'h43:   return FC[r];
      default: return 8'h00;
    endcase
  endfunction

  // Reference pixel from the window/cell/glyph/attribute rules.
  function automatic logic exp_pix(input int px, input int py);
    int dx, dy, col, row, gr, b;
    logic [8:0] e;
    logic [7:0] g;
    logic p;
    if (px < X0 || px >= X0 + COLS * 8 * (1 << SCALE) ||
        py < Y0 || py >= Y0 + ROWS * 16 * (1 << SCALE)) return 1'b0;
    dx  = px - X0;
    dy  = py - Y0;
    col = dx / (8 << SCALE);
    row = dy / (16 << SCALE);
    gr  = (dy / (1 << SCALE)) % 16;
    b   = (dx / (1 << SCALE)) % 8;
    e   = mbuf[row * COLS + col];
    g   = font(e[6:0], gr);
    p   = g[7 - b] ^ e[7];
    if (e[8] && ((strobes / BF) % 2 == 1)) p = 1'b0;
    return p;
  endfunction

  // Monitor: compare every expected pixel on the cycle it falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due != cyc) begin
          checks++;
          failures++;
          $display("FAIL pix_late x=%0d y=%0d actual_cycle=%0d required_cycle=%0d", e.px, e.py, cyc, e.due);
        end else begin
          chk($sformatf("pix_on(%0d,%0d)", e.px, e.py), 32'(text_on), 32'(e.on));
          chk($sformatf("pix_rgb(%0d,%0d)", e.px, e.py), 32'(text_rgb), e.on ? 32'hFFF : 32'h000);
        end
      end
    end
  end

  task automatic defaults();
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic pix(input int px, input int py);
    @(negedge clk);
    defaults();
    x = 10'(px);
    y = 10'(py);
    sbq.push_back('{due: cyc + 3, px: px, py: py, on: exp_pix(px, py)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      defaults();
      x = 10'd700;
      y = 10'd700;
    end
  endtask

  task automatic wr(input int r, input int c, input logic [6:0] ch, input logic [1:0] at);
    @(negedge clk);
    defaults();
    bus.wr_valid = 1'b1;
    bus.wr_row   = 2'(r);
    bus.wr_col   = 5'(c);
    bus.wr_char  = ch;
    bus.wr_attr  = at;
    #1 chk("wr_ready", 32'(bus.wr_ready), 32'd1);
    mbuf[r * COLS + c] = {at, ch};
  endtask

  task automatic frame();
    @(negedge clk);
    defaults();
    x = 10'd0;
    y = 10'd0;
    strobes++;
    for (int i = 0; i < 8; i++) pix(2 * i, 46);
    idle(3);
  endtask

  // Count consecutive busy cycles; optionally pulse clr_req on busy cycle restart_at.
  task automatic count_busy(input int restart_at, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      bus.clr_req = (n == restart_at);
      @(negedge clk);
    end
    bus.clr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r, c;
    logic [6:0] ch;
    logic [1:0] at;
    x = 10'd700; y = 10'd700;
    bus.wr_valid = 1'b0; bus.clr_req = 1'b0;
    bus.wr_row = '0; bus.wr_col = '0; bus.wr_char = '0; bus.wr_attr = '0;
    foreach (mbuf[i]) mbuf[i] = 9'h000;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_text_on", 32'(text_on), 32'd0);
    chk("rst_text_rgb", 32'(text_rgb), 32'h000);

    // Reset in the middle of the automatic clear aborts it.
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("autoclr_busy", 32'(bus.busy), 32'd1);
    chk("autoclr_wr_ready", 32'(bus.wr_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    @(negedge clk);
    count_busy(0, n);
    chk("init_clear_len", 32'(n), 32'd128);
    chk("init_ready_after", 32'(bus.wr_ready), 32'd1);

    // Cleared buffer: sparse raster is dark everywhere.
    for (int yy = 28; yy < 165; yy += 5)
      for (int xx = 0; xx < 520; xx += 13) pix(xx, yy);

    // 'A' plain, then inverted, at row 0 col 0.
    wr(0, 0, 7'h41, 2'b00);
    for (int yy = 32; yy < 64; yy++)
      for (int xx = 0; xx < 16; xx++) pix(xx, yy);
    wr(0, 0, 7'h41, 2'b01);
    for (int yy = 32; yy < 64; yy++)
      for (int xx = 0; xx < 16; xx++) pix(xx, yy);
    pix(1023, 40);
    pix(512, 40);
    pix(5, 31);
    pix(5, 160);

    // Same-cycle write and read of one cell: old value, then new value.
    wr(0, 0, 7'h41, 2'b00);
    @(negedge clk);
    defaults();
    x = 10'd1; y = 10'd36;
    bus.wr_valid = 1'b1; bus.wr_row = 2'd0; bus.wr_col = 5'd0;
    bus.wr_char = 7'h42; bus.wr_attr = 2'b00;
    sbq.push_back('{due: cyc + 3, px: 1, py: 36, on: exp_pix(1, 36)});
    mbuf[0] = {2'b00, 7'h42};
    pix(1, 36);

    // Random writes with pixels inside the written cell and anywhere.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(ROWS - 1);
      c = $urandom_range(COLS - 1);
      case ($urandom_range(4))
        0: ch = 7'h41;
        1: ch = 7'h42;
        2: ch = 7'h43;
        3: ch = 7'h20;
        default: ch = 7'($urandom_range(127));
      endcase
      at = 2'($urandom_range(3));
      wr(r, c, ch, at);
      for (int j = 0; j < 6; j++)
        pix(X0 + c * 16 + $urandom_range(15), Y0 + r * 32 + $urandom_range(31));
      for (int j = 0; j < 4; j++)
        pix($urandom_range(600), $urandom_range(200, 1));
    end

    // Blink attribute over 120 frames.
    wr(0, 0, 7'h41, 2'b10);
    idle(2);
    for (int f = 0; f < 120; f++) frame();

    // Clear beats a same-cycle write; a second request restarts the sweep.
    @(negedge clk);
    defaults();
    x = 10'd700; y = 10'd700;
    bus.clr_req = 1'b1; bus.wr_valid = 1'b1;
    bus.wr_row = 2'd1; bus.wr_col = 5'd1; bus.wr_char = 7'h43; bus.wr_attr = 2'b00;
    #1 chk("clr_vs_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    defaults();
    chk("clr_busy", 32'(bus.busy), 32'd1);
    count_busy(50, n);
    chk("restart_clear_len", 32'(n), 32'd178);
    chk("clr_ready_after", 32'(bus.wr_ready), 32'd1);
    foreach (mbuf[i]) mbuf[i] = 9'h000;
    for (int yy = 32; yy < 96; yy += 3)
      for (int xx = 0; xx < 48; xx += 3) pix(xx, yy);

    idle(1);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
